// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    // Encoding doubles as the debug owner code: 00 none, 01 port 0, 10 port 1.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

    localparam int NUM_PORTS = 2;

endpackage

// File: rtl/dff.sv
// Generic register with asynchronous active-high reset and load enable.
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load d when enabled; reset forces RST_VAL immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-input round-robin picker producing a one-hot grant.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    // A lone requester wins; on a tie the port named by prio wins.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU (port 0) and the loader (port 1)
// with round-robin arbitration, locked ownership for RMW sequences and
// 1-cycle tagged read return.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int Wwid = 6,
    parameter int aW   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic            m0_lock,
    input  logic [aW-1:0]   m0_addr,
    input  logic [Wwid-1:0] m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [Wwid-1:0] m0_rdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic            m1_lock,
    input  logic [aW-1:0]   m1_addr,
    input  logic [Wwid-1:0] m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [Wwid-1:0] m1_rdata,
    output logic [aW-1:0]   mem_addr,
    output logic [Wwid-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [Wwid-1:0] mem_rdata,
    output logic [1:0]      owner
);

    logic [1:0]           state_raw_q;
    arb_state_t           state_q, state_d;
    logic                 prio_q, prio_d;
    logic                 rv0_q, rv0_d;
    logic                 rv1_q, rv1_d;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] pick;
    logic [NUM_PORTS-1:0] gnt;

    assign req     = {m1_req, m0_req};
    assign state_q = arb_state_t'(state_raw_q);

    rr_pick2 u_pick (
        .req  (req),
        .prio (prio_q),
        .gnt  (pick)
    );

    // Grant: round-robin when idle, only the lock holder while locked.
    always_comb begin
        gnt = '0;
        case (state_q)
            IDLE:    gnt = pick;
            OWN0:    gnt = {1'b0, m0_req};
            OWN1:    gnt = {m1_req, 1'b0};
            default: gnt = '0;
        endcase
    end

    // Memory mux: the granted port drives the memory, otherwise all zero.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (gnt[0]) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_we;
        end else if (gnt[1]) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
        end
    end

    // Next state, priority and read-return tags. A locked grant holds
    // ownership and leaves prio alone; any other outcome falls back to IDLE,
    // which also covers a lock holder dropping req. prio flips only on an
    // unlocked grant so the final access of a locked sequence hands over.
    always_comb begin
        state_d = IDLE;
        prio_d  = prio_q;
        if (gnt[0] && m0_lock)
            state_d = OWN0;
        else if (gnt[1] && m1_lock)
            state_d = OWN1;
        if (gnt[0] && !m0_lock)
            prio_d = 1'b1;
        else if (gnt[1] && !m1_lock)
            prio_d = 1'b0;
        rv0_d = gnt[0] && !m0_we;
        rv1_d = gnt[1] && !m1_we;
    end

    dff #(.W(2), .RST_VAL(2'b00)) u_state (
        .clk (clk), .rst (rst), .en (1'b1), .d (state_d), .q (state_raw_q)
    );
    dff #(.W(1), .RST_VAL(1'b0)) u_prio (
        .clk (clk), .rst (rst), .en (1'b1), .d (prio_d), .q (prio_q)
    );
    dff #(.W(1), .RST_VAL(1'b0)) u_rv0 (
        .clk (clk), .rst (rst), .en (1'b1), .d (rv0_d), .q (rv0_q)
    );
    dff #(.W(1), .RST_VAL(1'b0)) u_rv1 (
        .clk (clk), .rst (rst), .en (1'b1), .d (rv1_d), .q (rv1_q)
    );

    // Outputs: grants, tagged read return gated by its valid, debug owner.
    always_comb begin
        m0_gnt    = gnt[0];
        m1_gnt    = gnt[1];
        m0_rvalid = rv0_q;
        m1_rvalid = rv1_q;
        m0_rdata  = rv0_q ? mem_rdata : '0;
        m1_rdata  = rv1_q ? mem_rdata : '0;
        owner     = state_raw_q;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port (address, read data, write data, write enable) between two requesters: port 0 is the CPU core and port 1 is the loader/debug master.
- Arbitration is round-robin. It supports locked multi-cycle ownership for read-modify-write sequences such as page-table updates.
- Read data returns with a fixed 1-cycle latency, tagged to the requester that issued the read.
- Sits between the CPU/loader and the memory model, replacing the direct memAddr/readData/writeData/writeEn connection.

Parameters:
- Wwid, 6, data word width
- aW, 6, memory address width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- m0_req  input  1  port 0 requests an access this cycle
- m0_we  input  1  port 0 access is a write
- m0_lock  input  1  port 0 keeps ownership after this access
- m0_addr  input  aW  port 0 address
- m0_wdata  input  Wwid  port 0 write data
- m0_gnt  output  1  port 0 access accepted this cycle
- m0_rvalid  output  1  port 0 read data valid
- m0_rdata  output  Wwid  port 0 read data
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- mem_addr  output  aW  memory address
- mem_wdata  output  Wwid  memory write data
- mem_we  output  1  memory write enable
- mem_rdata  input  Wwid  memory read data, valid 1 cycle after the address is presented
- owner  output  2  debug: 00 none, 01 port 0, 10 port 1

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, prio=0 (port 0 favoured), rv0=rv1=0, owner=00. All gnt outputs are 0 while no req is present.
- FSM states:
  - IDLE: no owner.
  - OWN0: port 0 holds a lock.
  - OWN1: port 1 holds a lock.
- Grant is combinational from req and state, with at most one gnt per cycle:
  - IDLE, only one req: that port wins.
  - IDLE, both req: the port equal to prio wins.
  - OWN0: only port 0 can win, and only if m0_req. Port 1 gets no gnt.
  - OWN1: mirror of OWN0.
- Memory mux:
  - When port x has gnt: mem_addr=mx_addr, mem_wdata=mx_wdata, mem_we=mx_we.
  - With no grant: mem_addr=0, mem_wdata=0, mem_we=0.
- State transitions at the clock edge:
  - Grant to port x with mx_lock=1 → OWNx.
  - In OWNx, if mx_req=0 or mx_lock=0 on the granted access, the next state is IDLE. An unlocked final access is still performed.
  - In OWNx with mx_req=0, the lock is released (IDLE) the same edge. No grant is given that cycle.
- Priority update on every grant: prio becomes the other port, so a continuously requesting loser wins next time.
  - A locked sequence updates prio only on its final (unlocked) access.
- Read return:
  - A granted read by port x (we=0) sets rvx=1 on the next edge. Otherwise rvx=0.
  - mx_rvalid=rvx.
  - mx_rdata=mem_rdata when rvx, else 0.
  - Back-to-back reads return every cycle. Writes never produce rvalid.
- Simultaneous events:
  - A read return to port 0 and a new grant to port 1 in the same cycle are legal and independent.
  - Requester address/data must stay stable only during the gnt cycle.
- Reset mid-operation: an asynchronous rst immediately clears the lock, pending rvalid, and prio. An in-flight read is dropped with no rvalid.
- No starvation: without locks, the worst-case wait is 1 grant. A lock may be held indefinitely; the requester bounds it.
- owner reflects state: IDLE=00, OWN0=01, OWN1=10.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t
  - localparam NUM_PORTS=2
- Registers (state, prio, rv0, rv1) use the existing dff module, with en tied to 1 where unconditional.
- Sub-module rr_pick2: combinational 2-input round-robin picker. Inputs are req[1:0] and prio; output is a one-hot grant.

Test Plan:
- Reset: assert rst mid-cycle with no clk edge → all gnt/rvalid=0, owner=00 immediately. Release, drive m0 read addr 5 → m0_gnt=1, mem_addr=5, mem_we=0. Next cycle m0_rvalid=1, m0_rdata=mem[5].
- Contention: m0 and m1 both request reads of addr 1 and addr 2 for 4 cycles → grants alternate 0,1,0,1 and mem_addr alternates 1,2,1,2. rvalid follows one cycle behind on the matching port.
- Write: m1 write addr 9 data 6'h2A, alone → mem_we=1, mem_addr=9, mem_wdata=2A. No m1_rvalid next cycle.
- Lock: m0 locked read addr 3, then unlocked write addr 3 data 7, while m1_req is held high → m0 gets both grants and owner=01 between them. m1 is granted the cycle after the write, and owner returns to 00.
- Lock abandon: in OWN1, m1 drops req → no grant that cycle, state IDLE next edge. A pending m0_req is granted the following cycle.
- Reset in flight: grant a read to m0, then assert rst before the next edge → m0_rvalid stays 0 and prio returns to 0.
